// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//   Writable byte-addressed instruction memory. A boot/debug host streams
//   instruction bytes in over a valid/ready byte port; bytes are stored
//   little-endian starting at address 0. The fetch stage reads 32-bit words
//   through the usual pc/ins interface. While a load is in progress, fetch
//   returns NOP_WORD so the core never executes partially written code.
//
// Optional feature macro: IM_LOADER_CHECKSUM_EN
//   Defined   : csum accumulates the mod-256 sum of the accepted bytes.
//   Undefined : csum is tied to 8'h00 and no adder is built.
//
// Parameters
//   ADDR_W    byte-address width, memory depth is 2**ADDR_W bytes
//   NOP_WORD  word driven on ins while loading
//
// Ports
//   clk       system clock, all state updates on the rising edge
//   rst       synchronous active-high reset (memory contents are kept)
//   start     single-cycle pulse that begins a load session
//   load_len  byte count, sampled on an accepted start
//   wr_valid  host byte valid
//   wr_data   host byte
//   wr_ready  block accepts a byte this cycle (registered)
//   busy      load session active (registered)
//   done      last session completed, sticky until next start or rst
//   len_err   last sampled load_len exceeded the depth and was clamped
//   csum      running byte checksum
//   pc        fetch byte address
//   ins       fetched word (combinational)
// -----------------------------------------------------------------------------
module im_loader #(
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              wr_valid,
   input  logic [7:0]        wr_data,
   output logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              len_err,
   output logic [7:0]        csum,
   input  logic [ADDR_W-1:0] pc,
   output logic [31:0]       ins
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   remaining;
   logic [7:0]        mem [DEPTH];

   logic              accept;
   logic              start_ok;
   logic [ADDR_W:0]   start_len;

   // Saturate the requested length to the memory depth so wr_ptr never wraps.
   function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

   // wr_ready is only ever high in LOAD, so this is the complete accept term.
   assign accept    = wr_valid & wr_ready;
   assign start_ok  = start & (state != LOAD);
   assign start_len = sat_len(load_len);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         remaining <= '0;
         wr_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         len_err   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  wr_ptr    <= '0;
                  remaining <= start_len;
                  len_err   <= (load_len > MAX_LEN);
                  if (start_len == '0) begin
                     // Empty session completes immediately.
                     state    <= DONE;
                     done     <= 1'b1;
                     wr_ready <= 1'b0;
                     busy     <= 1'b0;
                  end else begin
                     state    <= LOAD;
                     done     <= 1'b0;
                     wr_ready <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  wr_ptr    <= wr_ptr + ADDR_W'(1);
                  remaining <= remaining - (ADDR_W + 1)'(1);
                  if (remaining == (ADDR_W + 1)'(1)) begin
                     // Last byte: drop ready on the same edge, no extra accept.
                     state    <= DONE;
                     done     <= 1'b1;
                     wr_ready <= 1'b0;
                     busy     <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               wr_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   // Memory array: no reset, contents survive rst.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= wr_data;
      end
   end

`ifdef IM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         csum <= 8'h00;
      end else if (start_ok) begin
         csum <= 8'h00;
      end else if (accept) begin
         csum <= csum + wr_data;
      end
   end
`else
   assign csum = 8'h00;
`endif

   // Fetch: little-endian word, byte addresses wrap modulo the depth.
   logic [ADDR_W-1:0] pc1, pc2, pc3;
   assign pc1 = pc + ADDR_W'(1);
   assign pc2 = pc + ADDR_W'(2);
   assign pc3 = pc + ADDR_W'(3);

   always_comb begin
      ins = NOP_WORD;
      if (state != LOAD) begin
         ins = {mem[pc3], mem[pc2], mem[pc1], mem[pc]};
      end
   end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W:0]   load_len;
   logic              wr_valid;
   logic [7:0]        wr_data;
   logic              wr_ready;
   logic              busy;
   logic              done;
   logic              len_err;
   logic [7:0]        csum;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       ins;

   int checks   = 0;
   int failures = 0;

   logic [7:0] tx [1024];
   int         acc_cnt;
   logic [7:0] sum_model;

   im_loader #(.ADDR_W(ADDR_W), .NOP_WORD(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .start(start), .load_len(load_len),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .busy(busy), .done(done), .len_err(len_err), .csum(csum),
      .pc(pc), .ins(ins)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_csum(input logic [7:0] s);
`ifdef IM_LOADER_CHECKSUM_EN
      return s;
`else
      return 8'h00;
`endif
   endfunction

   task automatic do_start(input int len);
      start    = 1'b1;
      load_len = (ADDR_W + 1)'(len);
      tick();
      start    = 1'b0;
   endtask

   // Stream tx[] bytes. Valid is high one cycle in every (gap+1). Stops on done
   // or after max_acc accepts. A spurious start pulse is raised at cycle start_at.
   task automatic stream(input int gap, input int max_acc, input int start_at, input int budget);
      int cyc;
      acc_cnt   = 0;
      sum_model = 8'h00;
      cyc       = 0;
      while (!done && acc_cnt < max_acc && cyc < budget) begin
         wr_valid = ((cyc % (gap + 1)) == 0);
         wr_data  = tx[acc_cnt];
         start    = (cyc == start_at);
         load_len = 11'd2;
         if (wr_valid && wr_ready) begin
            sum_model = sum_model + tx[acc_cnt];
            acc_cnt++;
         end
         tick();
         cyc++;
      end
      wr_valid = 1'b0;
      start    = 1'b0;
      if (cyc >= budget) chk("stream_timeout", 32'(cyc), 32'(budget - 1));
   endtask

   initial begin
      logic [7:0] pat8 [8];
      pat8 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      rst = 1'b1; start = 1'b0; load_len = '0; wr_valid = 1'b0; wr_data = '0; pc = '0;
      tick(); tick();
      chk("rst0_ready", 32'(wr_ready), 0);
      chk("rst0_busy",  32'(busy), 0);
      chk("rst0_done",  32'(done), 0);
      chk("rst0_csum",  32'(csum), 0);
      rst = 1'b0;
      tick();

      // Plain 8-byte load, valid always high.
      for (int i = 0; i < 8; i++) tx[i] = pat8[i];
      do_start(8);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_ready", 32'(wr_ready), 1);
      chk("t1_done_clr", 32'(done), 0);
      stream(0, 100, -1, 100);
      chk("t1_acc", 32'(acc_cnt), 8);
      chk("t1_done", 32'(done), 1);
      chk("t1_ready_lo", 32'(wr_ready), 0);
      chk("t1_busy_lo", 32'(busy), 0);
      chk("t1_lenerr", 32'(len_err), 0);
      pc = 10'd0; #1 chk("t1_ins0", ins, 32'h1234_5678);
      pc = 10'd4; #1 chk("t1_ins4", ins, 32'hDEAD_BEEF);
      chk("t1_csum", 32'(csum), 32'(exp_csum(8'h4C)));
      chk("t1_csum_model", 32'(csum), 32'(exp_csum(sum_model)));

      // Same load with gaps and an ignored mid-load start.
      do_start(8);
      pc = 10'd0; #1 chk("t2_nop", ins, 32'h0000_0000);
      stream(2, 100, 7, 200);
      chk("t2_acc", 32'(acc_cnt), 8);
      chk("t2_done", 32'(done), 1);
      pc = 10'd0; #1 chk("t2_ins0", ins, 32'h1234_5678);
      pc = 10'd4; #1 chk("t2_ins4", ins, 32'hDEAD_BEEF);
      pc = 10'd2; #1 chk("t2_unaligned", ins, 32'hBEEF_1234);

      // Random traffic outside LOAD, then reset.
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_data  = 8'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      chk("rst1_ready", 32'(wr_ready), 0);
      chk("rst1_busy",  32'(busy), 0);
      chk("rst1_done",  32'(done), 0);
      chk("rst1_lenerr", 32'(len_err), 0);
      chk("rst1_csum",  32'(csum), 0);
      pc = 10'd0; #1 chk("rst1_mem_kept", ins, 32'h1234_5678);

      // Oversized length: clamped to 1024 bytes.
      for (int i = 0; i < 1024; i++) tx[i] = 8'(i);
      tx[0] = 8'h11; tx[1] = 8'h22; tx[1022] = 8'hAA; tx[1023] = 8'hBB;
      do_start(1500);
      chk("t3_lenerr", 32'(len_err), 1);
      stream(0, 2000, -1, 1100);
      chk("t3_acc", 32'(acc_cnt), 1024);
      chk("t3_done", 32'(done), 1);
      chk("t3_lenerr_hold", 32'(len_err), 1);
      pc = 10'd1022; #1 chk("t3_wrap", ins, 32'h2211_BBAA);
      pc = 10'd4;    #1 chk("t3_ins4", ins, 32'h0706_0504);
      chk("t3_csum", 32'(csum), 32'(exp_csum(sum_model)));

      // Zero length: straight to DONE, ready never rises.
      do_start(0);
      chk("t4_done", 32'(done), 1);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_lenerr", 32'(len_err), 0);
      chk("t4_csum", 32'(csum), 0);
      wr_valid = 1'b1; wr_data = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         chk("t4_ready", 32'(wr_ready), 0);
         tick();
      end
      wr_valid = 1'b0;
      pc = 10'd0; #1 chk("t4_mem", ins, 32'h0302_2211);

      // Reset mid-load after 3 bytes, then a fresh 4-byte load.
      for (int i = 0; i < 8; i++) tx[i] = 8'hC0 + 8'(i);
      do_start(8);
      stream(0, 3, -1, 50);
      chk("t5_partial", 32'(acc_cnt), 3);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5_done", 32'(done), 0);
      chk("t5_busy", 32'(busy), 0);
      pc = 10'd0; #1 chk("t5_fetch_idle", ins, 32'h03C2_C1C0);
      tx[0] = 8'hA1; tx[1] = 8'hA2; tx[2] = 8'hA3; tx[3] = 8'hA4; tx[4] = 8'hFF;
      do_start(4);
      stream(0, 100, -1, 50);
      chk("t5_acc", 32'(acc_cnt), 4);
      chk("t5_done2", 32'(done), 1);
      pc = 10'd0; #1 chk("t5_ins0", ins, 32'hA4A3_A2A1);
      pc = 10'd4; #1 chk("t5_ins4", ins, 32'h0706_0504);
      chk("t5_csum", 32'(csum), 32'(exp_csum(8'h8A)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
